inst_fetch_queue: RTL and testbench

//  Instruction fetch queue between the fetch stage and decode. Fetch pushes {pc, instruction} pairs
//  as the instruction bus returns them; decode pops them in order under a valid/ready handshake.
//  A redirect (jump/branch taken) flushes every queued wrong-path word in one cycle.

---
 rtl/inst_fetch_queue_if.sv | 28 ++
 rtl/inst_fetch_queue.sv | 115 +++++++++++
 tb/tb_inst_fetch_queue.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between fetch (push side), the instruction fetch queue and decode (pop side).
// master = the fetch/decode environment, slave = the queue itself.
interface inst_fetch_queue_if #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int CW = 3
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_pc;
    logic [DW-1:0] in_inst;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [DW-1:0] out_inst;
    logic [CW-1:0] count;

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: in-order {pc, inst} FIFO between fetch and decode with one-cycle flush.
// Define FETCHQ_BYPASS_EN to add a zero-latency in->out path while the queue is empty.
module inst_fetch_queue #(
    parameter int            DEPTH    = 4,
    parameter int            AW       = 16,
    parameter int            DW       = 16,
    parameter logic [DW-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_queue_if.slave q
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [AW-1:0] pc_mem_q   [DEPTH];
    logic [DW-1:0] inst_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;

    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          empty;
    logic          full;
    logic          push_en;
    logic          pop_en;
    logic          bypass_hit;

    assign wr_idx = wr_ptr_q[IW-1:0];
    assign rd_idx = rd_ptr_q[IW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);

`ifdef FETCHQ_BYPASS_EN
    assign bypass_hit = empty & q.in_valid & ~q.flush;
`else
    assign bypass_hit = 1'b0;
`endif

    assign q.in_ready = ~full;
    assign q.count    = count_q;

    always_comb begin
        q.out_valid = 1'b0;
        q.out_pc    = '0;
        q.out_inst  = NOP_INST;
        if (!empty) begin
            q.out_valid = 1'b1;
            q.out_pc    = pc_mem_q[rd_idx];
            q.out_inst  = inst_mem_q[rd_idx];
        end else if (bypass_hit) begin
            q.out_valid = 1'b1;
            q.out_pc    = q.in_pc;
            q.out_inst  = q.in_inst;
        end
    end

    // A bypassed word that decode takes immediately is never written into the array.
    always_comb begin
        push_en = q.in_valid & ~full & ~q.flush & ~(bypass_hit & q.out_ready);
        pop_en  = q.out_ready & ~empty & ~q.flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + PTR_ONE;
                2'b01:   count_d = count_q - PTR_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; entries are only observable once written.
    always_ff @(posedge clk) begin
        if (push_en) begin
            pc_mem_q[wr_idx]   <= q.in_pc;
            inst_mem_q[wr_idx] <= q.in_inst;
        end
    end

    a_count_range : assert property (@(posedge clk) disable iff (rst)
        count_q <= PW'(DEPTH));
    a_full_count  : assert property (@(posedge clk) disable iff (rst)
        full == (count_q == PW'(DEPTH)));
    a_empty_count : assert property (@(posedge clk) disable iff (rst)
        empty == (count_q == '0));
    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (q.out_valid && !q.out_ready && !q.flush) |=>
            (q.out_valid && $stable(q.out_pc) && $stable(q.out_inst)));
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4, AW=DW=16, non-zero NOP_INST).
module tb_inst_fetch_queue;
    localparam logic [15:0] NOP = 16'hA5A5;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    inst_fetch_queue_if #(.AW(16), .DW(16), .CW(3)) bus ();

    inst_fetch_queue #(
        .DEPTH(4), .AW(16), .DW(16), .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .q  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] inst_of(input logic [15:0] pc);
        return pc ^ 16'hF000;
    endfunction

    task automatic drive(input logic v, input logic [15:0] pc, input logic rdy);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst_of(pc);
        bus.out_ready = rdy;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.flush = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_count",     32'(bus.count),     32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_pc",    32'(bus.out_pc),    32'd0);
        chk("rst_out_inst",  32'(bus.out_inst),  32'(NOP));
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Fill to full with decode held, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0010 + 16'(i), 1'b0);
            tick();
        end
        drive(1'b1, 16'h0014, 1'b0);
        #1;
        chk("fill_count",    32'(bus.count),    32'd4);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fill_head_pc",  32'(bus.out_pc),   32'h0010);
        tick();
        chk("fill_refused_count", 32'(bus.count),  32'd4);
        chk("fill_hold_pc",       32'(bus.out_pc), 32'h0010);
        drive(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_pc",    32'(bus.out_pc),    32'(16'h0010 + 16'(i)));
            chk("drain_inst",  32'(bus.out_inst),  32'(inst_of(16'h0010 + 16'(i))));
            tick();
        end
        chk("drain_empty_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_empty_count", 32'(bus.count),     32'd0);
        chk("drain_empty_inst",  32'(bus.out_inst),  32'(NOP));
        chk("drain_empty_pc",    32'(bus.out_pc),    32'd0);

        // Sustained push+pop across pointer wrap
        drive(1'b1, 16'h0020, 1'b0); tick();
        drive(1'b1, 16'h0021, 1'b0); tick();
        for (int i = 2; i < 10; i++) begin
            drive(1'b1, 16'h0020 + 16'(i), 1'b1);
            #1;
            chk("wrap_count", 32'(bus.count),  32'd2);
            chk("wrap_pc",    32'(bus.out_pc), 32'(16'h0020 + 16'(i - 2)));
            tick();
        end
        drive(1'b0, 16'h0, 1'b1);
        #1;
        chk("wrap_tail0", 32'(bus.out_pc), 32'h0028);
        tick();
        chk("wrap_tail1",      32'(bus.out_pc),   32'h0029);
        chk("wrap_tail1_inst", 32'(bus.out_inst), 32'(inst_of(16'h0029)));
        tick();
        chk("wrap_done_valid", 32'(bus.out_valid), 32'd0);

        // Flush with a same-cycle push that must be dropped
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0030 + 16'(i), 1'b0);
            tick();
        end
        drive(1'b0, 16'h0, 1'b0);
        #1;
        chk("flush_pre_count", 32'(bus.count), 32'd3);
        bus.flush = 1'b1;
        drive(1'b1, 16'h0040, 1'b0);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 16'h0, 1'b1);
        #1;
        chk("flush_count",    32'(bus.count),     32'd0);
        chk("flush_valid",    32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready),  32'd1);
        chk("flush_inst",     32'(bus.out_inst),  32'(NOP));
        tick();
        chk("flush_no_0040", 32'(bus.out_valid), 32'd0);

        // Push and pop together while full: pop only
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0070 + 16'(i), 1'b0);
            tick();
        end
        drive(1'b1, 16'h0074, 1'b1);
        #1;
        chk("full_both_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("full_both_count", 32'(bus.count),    32'd3);
        chk("full_both_head",  32'(bus.out_pc),   32'h0071);
        chk("full_both_rdy",   32'(bus.in_ready), 32'd1);
        drive(1'b1, 16'h0074, 1'b0);
        tick();
        chk("full_retry_count", 32'(bus.count), 32'd4);
        drive(1'b0, 16'h0, 1'b1);
        for (int i = 1; i < 5; i++) begin
            #1;
            chk("full_drain_pc", 32'(bus.out_pc), 32'(16'h0070 + 16'(i)));
            tick();
        end
        chk("full_drain_empty", 32'(bus.out_valid), 32'd0);

        // Empty queue, word offered with decode ready
        bus.in_valid  = 1'b1;
        bus.in_pc     = 16'h0050;
        bus.in_inst   = 16'h1234;
        bus.out_ready = 1'b1;
        #1;
`ifdef FETCHQ_BYPASS_EN
        chk("byp_valid", 32'(bus.out_valid), 32'd1);
        chk("byp_inst",  32'(bus.out_inst),  32'h1234);
        chk("byp_pc",    32'(bus.out_pc),    32'h0050);
        chk("byp_count", 32'(bus.count),     32'd0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("byp_after_count", 32'(bus.count),     32'd0);
        chk("byp_after_valid", 32'(bus.out_valid), 32'd0);
`else
        chk("nobyp_valid", 32'(bus.out_valid), 32'd0);
        chk("nobyp_inst",  32'(bus.out_inst),  32'(NOP));
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("nobyp_next_valid", 32'(bus.out_valid), 32'd1);
        chk("nobyp_next_inst",  32'(bus.out_inst),  32'h1234);
        chk("nobyp_next_pc",    32'(bus.out_pc),    32'h0050);
        chk("nobyp_next_count", 32'(bus.count),     32'd1);
        tick();
        chk("nobyp_done_count", 32'(bus.count),     32'd0);
        chk("nobyp_done_valid", 32'(bus.out_valid), 32'd0);
`endif

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0060 + 16'(i), 1'b0);
            tick();
        end
        drive(1'b0, 16'h0, 1'b0);
        #1;
        chk("arst_pre_count", 32'(bus.count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count),     32'd0);
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_inst",  32'(bus.out_inst),  32'(NOP));
        chk("arst_pc",    32'(bus.out_pc),    32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_rel_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_rel_count", 32'(bus.count),    32'd0);
        tick();
        chk("arst_rel_valid", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
